uart_rx_fifo: RTL

//  Receive-side elastic buffer directly downstream of the UART receiver. Accepts bytes on an
//  AXI4-Stream slave, stores up to 2**ADDR_WIDTH entries, and presents them first-word-fall-through
//  on an AXI4-Stream master to the core's input-instruction logic. Also latches the receiver's
//  one-cycle overrun/frame error pulses into sticky flags and a saturating error counter.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_ram.sv | 24 ++
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART status constants, used by both the RX and TX status logic.
package uart_pkg;

  localparam int ERR_COUNT_WIDTH = 8;
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one asynchronous read port.
module uart_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver, with sticky error flags and a
// saturating error counter fed by the receiver's overrun/frame pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      input_axis_tdata,
  input  logic                       input_axis_tvalid,
  output logic                       input_axis_tready,
  output logic [DATA_WIDTH-1:0]      output_axis_tdata,
  output logic                       output_axis_tvalid,
  input  logic                       output_axis_tready,
  input  logic                       rx_overrun_error,
  input  logic                       rx_frame_error,
  input  logic                       clear_status,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun_sticky,
  output logic                       frame_sticky,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);

  logic [ADDR_WIDTH:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]        count_q, count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       overrun_q, overrun_d;
  logic                       frame_q, frame_d;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                       push, pop, err_pulse;

  assign push      = input_axis_tvalid & ~full_q;
  assign pop       = output_axis_tready & ~empty_q;
  assign err_pulse = rx_overrun_error | rx_frame_error;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};
    count_d     = wr_ptr_d - rd_ptr_d;
    // Same index with differing wrap bits means the write pointer lapped the read pointer.
    full_d      = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                  (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    empty_d     = (wr_ptr_d == rd_ptr_d);
    overrun_d   = overrun_q | rx_overrun_error;
    frame_d     = frame_q | rx_frame_error;
    err_count_d = err_count_q;
    if (clear_status) begin
      overrun_d   = rx_overrun_error;
      frame_d     = rx_frame_error;
      err_count_d = {{(ERR_COUNT_WIDTH-1){1'b0}}, err_pulse};
    end else if (err_pulse && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overrun_q   <= 1'b0;
      frame_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overrun_q   <= overrun_d;
      frame_q     <= frame_d;
      err_count_q <= err_count_d;
    end
  end

  uart_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & rst_n),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (input_axis_tdata),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (output_axis_tdata)
  );

  assign input_axis_tready  = ~full_q;
  assign output_axis_tvalid = ~empty_q;
  assign count              = count_q;
  assign full               = full_q;
  assign empty              = empty_q;
  assign overrun_sticky     = overrun_q;
  assign frame_sticky       = frame_q;
  assign err_count          = err_count_q;

endmodule
